// File: rtl/sram_pkg.sv
// Shared types, constants and the parity helper for the sram_sync storage block.
package sram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  // Collision behaviour selectors for a same-cycle read and write.
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Widest word the parity helper covers; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  // Even parity: the returned bit makes the total number of ones even.
  function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port storage array: one write port and a registered read with a
// selectable read-first / write-first collision mux.
module sram_array
  import sram_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              hit,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;

  // Out-of-range addresses alias here, but the caller gates them with hit.
  assign idx = addr[IDX_W-1:0];

  // NOTE: the storage array has no reset; a reset would turn it into flops.
  // The clear engine in the top level initialises the contents instead.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      if (!hit)                              rdata <= '0;
      else if (RD_MODE == WR_FIRST && we)    rdata <= wdata;
      else                                   rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/sram_sync.sv
// Parametrised synchronous single-port SRAM with a hardware clear engine.
// Optional per-word even parity is enabled by defining SRAM_PARITY_EN.
module sram_sync
  import sram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter int                RD_MODE  = RD_FIRST,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clear_req,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              ready,
  output logic              addr_err
`ifdef SRAM_PARITY_EN
  ,
  input  logic              par_inj,
  output logic              par_err
`endif
);

`ifdef SRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              acc;
  logic              in_range;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] init_word;

  assign acc      = cs && ready;
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign arr_re   = acc && rd;

`ifdef SRAM_PARITY_EN
  assign wr_word   = {parity(PAR_MAX_W'(din)) ^ par_inj, din};
  assign init_word = {parity(PAR_MAX_W'(INIT_VAL)), INIT_VAL};
`else
  assign wr_word   = din;
  assign init_word = INIT_VAL;
`endif

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = addr;
    arr_wdata = wr_word;
    if (state == ST_CLEAR) begin
      arr_we    = 1'b1;
      arr_addr  = ptr;
      arr_wdata = init_word;
    end else begin
      arr_we = acc && wr && in_range;
    end
  end

  sram_array #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .RD_MODE(RD_MODE)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (arr_we),
    .re   (arr_re),
    .hit  (in_range),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // Clear engine and strobes; ready is a registered copy of state == ST_IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      ptr        <= '0;
      ready      <= 1'b0;
      dout_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      dout_valid <= acc && rd;
      addr_err   <= acc && (rd || wr) && !in_range;
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dout = arr_rdata[DATA_W-1:0];

`ifdef SRAM_PARITY_EN
  assign par_err = dout_valid && (parity(PAR_MAX_W'(dout)) != arr_rdata[DATA_W]);
`endif

endmodule

// File: tb/tb_sram_sync.sv
// Scoreboard bench for sram_sync: two instances (256-deep read-first and
// 200-deep write-first) share one stimulus stream; monitors check each output.
module tb_sram_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0, wr = 1'b0, rd = 1'b0, clear_req = 1'b0, par_inj = 1'b0;
  logic [7:0] addr = 8'h00, din = 8'h00;
  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b, rdy_a, rdy_b, ae_a, ae_b;
`ifdef SRAM_PARITY_EN
  logic       pe_a, pe_b;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       vld;
    logic       err;
    logic       perr;
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] m_a[256];
  logic [7:0] m_b[200];
  logic       p_a[256];
  logic       p_b[200];

  sram_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .RD_MODE(0), .INIT_VAL(8'hA5)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din),
    .clear_req(clear_req), .dout(dout_a), .dout_valid(dv_a), .ready(rdy_a), .addr_err(ae_a)
`ifdef SRAM_PARITY_EN
    , .par_inj(par_inj), .par_err(pe_a)
`endif
  );

  sram_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .RD_MODE(1), .INIT_VAL(8'hA5)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din),
    .clear_req(clear_req), .dout(dout_b), .dout_valid(dv_b), .ready(rdy_b), .addr_err(ae_b)
`ifdef SRAM_PARITY_EN
    , .par_inj(par_inj), .par_err(pe_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic dv, input logic ae,
                     input logic pe, input logic [7:0] d);
    check({tag, "_valid"}, 32'(dv), 32'(e.vld));
    check({tag, "_addr_err"}, 32'(ae), 32'(e.err));
    if (e.vld) check({tag, "_dout"}, 32'(d), 32'(e.d));
`ifdef SRAM_PARITY_EN
    if (e.vld) check({tag, "_par_err"}, 32'(pe), 32'(e.perr));
`endif
  endtask

  // Monitors: an expected entry is due exactly one cycle after its request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q_a.size() != 0 && q_a[0].due == cyc) begin
`ifdef SRAM_PARITY_EN
        cmp("a", q_a.pop_front(), dv_a, ae_a, pe_a, dout_a);
`else
        cmp("a", q_a.pop_front(), dv_a, ae_a, 1'b0, dout_a);
`endif
      end else if (dv_a || ae_a) begin
        check("a_unexpected_strobe", 32'({dv_a, ae_a}), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (q_b.size() != 0 && q_b[0].due == cyc) begin
`ifdef SRAM_PARITY_EN
        cmp("b", q_b.pop_front(), dv_b, ae_b, pe_b, dout_b);
`else
        cmp("b", q_b.pop_front(), dv_b, ae_b, 1'b0, dout_b);
`endif
      end else if (dv_b || ae_b) begin
        check("b_unexpected_strobe", 32'({dv_b, ae_b}), 32'd0);
      end
    end
  end

  function automatic void model_clear();
    foreach (m_a[i]) begin m_a[i] = 8'hA5; p_a[i] = 1'b0; end
    foreach (m_b[i]) begin m_b[i] = 8'hA5; p_b[i] = 1'b0; end
  endfunction

  // One request cycle; expectations for both instances come from the models.
  task automatic op(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = w; rd = r; addr = a; din = d;
    if (r) q_a.push_back('{vld: 1'b1, err: 1'b0, perr: p_a[a], d: m_a[a], due: cyc + 1});
    if (w) begin m_a[a] = d; p_a[a] = par_inj; end
    if (a >= 8'd200) begin
      if (r || w) q_b.push_back('{vld: r, err: 1'b1, perr: 1'b0, d: 8'h00, due: cyc + 1});
    end else begin
      if (r) q_b.push_back('{vld: 1'b1, err: 1'b0, perr: w ? par_inj : p_b[a],
                             d: w ? d : m_b[a], due: cyc + 1});
      if (w) begin m_b[a] = d; p_b[a] = par_inj; end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  // Counts clock edges from the current negedge until each ready is seen high.
  task automatic measure(output int na, output int nb);
    na = -1; nb = -1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      clear_req = 1'b0;
      if (na < 0 && rdy_a) na = k;
      if (nb < 0 && rdy_b) nb = k;
      if (na >= 0 && nb >= 0) break;
    end
  endtask

  initial begin
    int na, nb;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_valid_a", 32'(dv_a), 32'd0);
    check("rst_ready_a", 32'(rdy_a), 32'd0);
    check("rst_addr_err_a", 32'(ae_a), 32'd0);
    check("rst_dout_b", 32'(dout_b), 32'd0);
    check("rst_ready_b", 32'(rdy_b), 32'd0);

    // Initial clear takes exactly DEPTH cycles after release
    model_clear();
    rst_n = 1'b1;
    measure(na, nb);
    check("init_clear_cycles_a", 32'(na), 32'd256);
    check("init_clear_cycles_b", 32'(nb), 32'd200);
    op(1'b0, 1'b1, 8'd0, 8'h00);
    op(1'b0, 1'b1, 8'd128, 8'h00);
    op(1'b0, 1'b1, 8'd255, 8'h00);
    idle();

    // Fill every address, then back-to-back reads in scrambled order
    for (int i = 0; i < 256; i++) op(1'b1, 1'b0, 8'(i), 8'(i * 37 + 11));
    for (int i = 0; i < 256; i++) op(1'b0, 1'b1, 8'(i * 101 + 7), 8'h00);
    idle();

    // Same-cycle read and write: read-first on a, write-first on b
    op(1'b1, 1'b0, 8'd5, 8'h11);
    op(1'b1, 1'b1, 8'd5, 8'h22);
    op(1'b0, 1'b1, 8'd5, 8'h00);
    idle();

    // Out-of-range access on the 200-deep instance
    op(1'b1, 1'b0, 8'd210, 8'hFF);
    op(1'b0, 1'b1, 8'd210, 8'h00);
    op(1'b0, 1'b1, 8'd199, 8'h00);
    idle();

`ifdef SRAM_PARITY_EN
    par_inj = 1'b1;
    op(1'b1, 1'b0, 8'd7, 8'h3C);
    par_inj = 1'b0;
    op(1'b1, 1'b0, 8'd8, 8'h3C);
    op(1'b0, 1'b1, 8'd7, 8'h00);
    op(1'b0, 1'b1, 8'd8, 8'h00);
    idle();
`endif

    // Requested clear over filled memory, then read everything back
    @(negedge clk);
    clear_req = 1'b1;
    measure(na, nb);
    check("req_clear_cycles_a", 32'(na), 32'd257);
    check("req_clear_cycles_b", 32'(nb), 32'd201);
    model_clear();
    for (int i = 0; i < 256; i++) op(1'b0, 1'b1, 8'(i), 8'h00);
    idle();

    // Reset 100 cycles into a clear restarts it from word 0
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (99) @(negedge clk);
    op(1'b0, 1'b0, 8'd0, 8'h00);
    idle();
    rst_n = 1'b0;
    #1;
    check("midclear_rst_ready_a", 32'(rdy_a), 32'd0);
    check("midclear_rst_dout_a", 32'(dout_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(na, nb);
    check("restart_clear_cycles_a", 32'(na), 32'd256);
    check("restart_clear_cycles_b", 32'(nb), 32'd200);
    op(1'b0, 1'b1, 8'd0, 8'h00);
    op(1'b0, 1'b1, 8'd99, 8'h00);
    op(1'b0, 1'b1, 8'd255, 8'h00);
    idle();

    repeat (3) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
